// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: LSU FSM state encoding, access size codes and
// the alignment legality helper shared by the LSU files.
package core_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  // Size 2'b11 is handled as a word access.
  function automatic logic lsu_misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic r;
    unique case (1'b1)
      size == LSU_BYTE: r = 1'b0;
      size == LSU_HALF: r = lo[0];
      default:          r = |lo;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/core_lsu_if.sv
// core_lsu_if: LSU <-> data-cache request/response bus.
// master = LSU (drives dc_req_*), slave = cache (drives ack/resp).
interface core_lsu_if;

  logic        dc_req_val_out;
  logic        dc_req_we_out;
  logic [3:0]  dc_req_be_out;
  logic [31:0] dc_req_addr_out;
  logic [31:0] dc_req_wdata_out;
  logic        dc_req_ack_in;
  logic        dc_resp_val_in;
  logic [31:0] dc_resp_data_in;

  modport master (
    output dc_req_val_out,
    output dc_req_we_out,
    output dc_req_be_out,
    output dc_req_addr_out,
    output dc_req_wdata_out,
    input  dc_req_ack_in,
    input  dc_resp_val_in,
    input  dc_resp_data_in
  );

  modport slave (
    input  dc_req_val_out,
    input  dc_req_we_out,
    input  dc_req_be_out,
    input  dc_req_addr_out,
    input  dc_req_wdata_out,
    output dc_req_ack_in,
    output dc_resp_val_in,
    output dc_resp_data_in
  );

endinterface

// File: rtl/core_lsu_align.sv
// core_lsu_align: store byte-enables / lane replication (size_i, addr_lo_i,
// wdata_i -> be_o, wdata_o) and load shift + extend (ld_* -> rdata_o).
module core_lsu_align
  import core_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_lo_i,
  input  logic        ld_sign_i,
  input  logic [31:0] ld_raw_i,
  output logic [31:0] rdata_o
);

  logic [31:0] sh;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    unique case (1'b1)
      size_i == LSU_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      size_i == LSU_HALF: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
      end
    endcase
  end

  assign sh = ld_raw_i >> {ld_lo_i, 3'b000};

  always_comb begin
    rdata_o = sh;
    unique case (1'b1)
      ld_size_i == LSU_BYTE:
        rdata_o = {{24{ld_sign_i & sh[7]}}, sh[7:0]};
      ld_size_i == LSU_HALF:
        rdata_o = {{16{ld_sign_i & sh[15]}}, sh[15:0]};
      default:
        rdata_o = sh;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// core_lsu: mem-stage load/store unit; lsu_* from pipeline, dc bus to cache,
// stall/rdata/misalign back. Optional alignment check: LSU_MISALIGN_CHECK_EN.
module core_lsu
  import core_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req_in,
  input  logic        lsu_we_in,
  input  logic [1:0]  lsu_size_in,
  input  logic        lsu_sign_in,
  input  logic [31:0] lsu_addr_in,
  input  logic [31:0] lsu_wdata_in,
  core_lsu_if.master  dc,
  output logic [31:0] lsu_rdata_out,
  output logic        lsu_stall_out,
  output logic        lsu_misalign_out
);

  lsu_state_e  state_q;
  logic        val_q;
  logic        we_q;
  logic        sign_q;
  logic [1:0]  size_q;
  logic [1:0]  lo_q;
  logic [3:0]  be_q;
  logic [3:0]  be_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] wdata_d;
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;
  logic        legal;
  logic        accept;

  core_lsu_align u_align (
    .size_i    (lsu_size_in),
    .addr_lo_i (lsu_addr_in[1:0]),
    .wdata_i   (lsu_wdata_in),
    .be_o      (be_d),
    .wdata_o   (wdata_d),
    .ld_size_i (size_q),
    .ld_lo_i   (lo_q),
    .ld_sign_i (sign_q),
    .ld_raw_i  (dc.dc_resp_data_in),
    .rdata_o   (rdata_d)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  logic mis_q;

  assign legal = !lsu_misaligned(lsu_size_in, lsu_addr_in[1:0]);

  // One-cycle flag for a rejected access seen in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= (state_q == ST_IDLE) && lsu_req_in && !legal;
    end
  end

  assign lsu_misalign_out = mis_q;
`else
  assign legal            = 1'b1;
  assign lsu_misalign_out = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && lsu_req_in && legal;

  assign lsu_stall_out = accept
                      || (state_q == ST_REQ)
                      || (state_q == ST_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      val_q   <= 1'b0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
      lo_q    <= 2'b00;
      be_q    <= 4'b0000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_REQ;
            val_q   <= 1'b1;
            we_q    <= lsu_we_in;
            sign_q  <= lsu_sign_in;
            size_q  <= lsu_size_in;
            lo_q    <= lsu_addr_in[1:0];
            be_q    <= be_d;
            addr_q  <= {lsu_addr_in[31:2], 2'b00};
            wdata_q <= wdata_d;
          end
        end
        // A response arriving with the ack is not the load data.
        ST_REQ: begin
          if (dc.dc_req_ack_in) begin
            val_q   <= 1'b0;
            state_q <= we_q ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dc.dc_resp_val_in) begin
            rdata_q <= rdata_d;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign dc.dc_req_val_out   = val_q;
  assign dc.dc_req_we_out    = we_q;
  assign dc.dc_req_be_out    = be_q;
  assign dc.dc_req_addr_out  = addr_q;
  assign dc.dc_req_wdata_out = wdata_q;
  assign lsu_rdata_out       = rdata_q;

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: randomized + directed scoreboard bench for core_lsu
// with a behavioural cache responder and an arithmetic reference model.
`timescale 1ns/1ps
module tb_core_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req;
  logic        we;
  logic        sign;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        mis;

  always #5 clk = ~clk;

  core_lsu_if dc ();

  core_lsu u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lsu_req_in       (req),
    .lsu_we_in        (we),
    .lsu_size_in      (size),
    .lsu_sign_in      (sign),
    .lsu_addr_in      (addr),
    .lsu_wdata_in     (wdata),
    .dc               (dc),
    .lsu_rdata_out    (rdata),
    .lsu_stall_out    (stall),
    .lsu_misalign_out (mis)
  );

  typedef struct {
    bit        we;
    bit [1:0]  size;
    bit        sign;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] resp;
    int        d;
    int        r;
  } txn_t;

  typedef struct {
    bit        we;
    bit [3:0]  be;
    bit [31:0] addr;
    bit [31:0] wdata;
  } dreq_t;

  typedef struct {
    bit [31:0] rdata;
    int        stall;
  } done_t;

  txn_t  plan_q[$];
  dreq_t req_q[$];
  done_t done_q[$];

  int        errs = 0;
  int        checks = 0;
  int        cyc = 0;
  int        mis_exp_cyc = -1;
  bit        manual = 1'b0;
  bit [31:0] model_rdata = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit [3:0] m_be(bit [1:0] sz, bit [31:0] a);
    int o;
    o = int'(a % 4);
    if (sz == 2'd0) return 4'(1 << o);
    if (sz == 2'd1) return 4'(3 << ((o / 2) * 2));
    return 4'hF;
  endfunction

  function automatic bit [31:0] m_wd(bit [1:0] sz, bit [31:0] w);
    if (sz == 2'd0) return (w % 256) * 32'h0101_0101;
    if (sz == 2'd1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic bit [31:0] m_ld(bit [1:0] sz, bit sg,
                                     bit [31:0] a, bit [31:0] rs);
    bit [31:0] v;
    v = rs >> (8 * (a % 4));
    if (sz == 2'd0) begin
      v = v % 256;
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic bit m_illegal(bit [1:0] sz, bit [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return (a % 2) != 0;
    return (a % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic txn_t mk(bit w, bit [1:0] sz, bit sg,
                              bit [31:0] a, bit [31:0] wd,
                              bit [31:0] rs, int d, int r);
    txn_t t;
    t.we = w; t.size = sz; t.sign = sg; t.addr = a;
    t.wdata = wd; t.resp = rs; t.d = d; t.r = r;
    return t;
  endfunction

  // Called at posedge+1 with the DUT idle; returns at posedge+1 of
  // the cycle after DONE, leaving req asserted with the old fields.
  task automatic issue(txn_t t);
    dreq_t q;
    done_t dn;
    int    n;
    bit    seen;
    req = 1'b1; we = t.we; size = t.size; sign = t.sign;
    addr = t.addr; wdata = t.wdata;
    if (m_illegal(t.size, t.addr)) begin
      mis_exp_cyc = cyc + 1;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      return;
    end
    q.we = t.we;
    q.be = m_be(t.size, t.addr);
    q.addr = t.addr & ~32'd3;
    q.wdata = m_wd(t.size, t.wdata);
    if (!t.we) model_rdata = m_ld(t.size, t.sign, t.addr, t.resp);
    dn.rdata = model_rdata;
    dn.stall = t.we ? 1 + t.d : 1 + t.d + t.r;
    plan_q.push_back(t);
    req_q.push_back(q);
    done_q.push_back(dn);
    n = 0;
    seen = 1'b0;
    while (n < 200) begin
      @(negedge clk);
      if (stall) seen = 1'b1;
      else if (seen) break;
      n++;
    end
    if (n >= 200) begin
      chk("txn_timeout", 32'd1, 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $fatal(1, "transaction timeout");
    end
    @(posedge clk); #1;
  endtask

  // Cache responder: acks after p.d valid cycles, responds after p.r
  // WAIT cycles, and throws stray responses whenever no load is owed.
  initial begin : responder
    int   vcnt;
    int   wcnt;
    bit   have;
    bit   waiting;
    txn_t p;
    vcnt = 0; wcnt = 0; have = 1'b0; waiting = 1'b0;
    dc.dc_req_ack_in = 1'b0;
    dc.dc_resp_val_in = 1'b0;
    dc.dc_resp_data_in = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (manual) continue;
      dc.dc_req_ack_in = 1'b0;
      dc.dc_resp_val_in = 1'b0;
      dc.dc_resp_data_in = $urandom;
      if (!rst_n) begin
        vcnt = 0; have = 1'b0; waiting = 1'b0;
        continue;
      end
      if (waiting) begin
        wcnt++;
        if (wcnt == p.r) begin
          dc.dc_resp_val_in = 1'b1;
          dc.dc_resp_data_in = p.resp;
          waiting = 1'b0;
        end
      end else begin
        if (dc.dc_req_val_out) begin
          if (!have) begin
            if (plan_q.size() == 0) p = mk(1, 0, 0, 0, 0, 0, 1, 1);
            else p = plan_q.pop_front();
            have = 1'b1;
            vcnt = 0;
          end
          vcnt++;
          if (vcnt >= p.d) begin
            dc.dc_req_ack_in = 1'b1;
            have = 1'b0;
            if (!p.we) begin
              waiting = 1'b1;
              wcnt = 0;
            end
          end
        end
        if ($urandom_range(0, 2) == 0) dc.dc_resp_val_in = 1'b1;
      end
    end
  end

  initial begin : monitor
    int    run;
    bit    prev_val;
    dreq_t e;
    done_t dn;
    run = 0; prev_val = 1'b0;
    e.we = 0; e.be = 0; e.addr = 0; e.wdata = 0;
    forever begin
      @(negedge clk);
      if (manual || !rst_n) begin
        run = 0;
        prev_val = 1'b0;
        continue;
      end
      if (dc.dc_req_val_out) begin
        if (!prev_val) begin
          if (req_q.size() == 0) chk("extra_req", 32'd1, 32'd0);
          else e = req_q.pop_front();
        end
        chk("req_we", 32'(dc.dc_req_we_out), 32'(e.we));
        chk("req_be", 32'(dc.dc_req_be_out), 32'(e.be));
        chk("req_addr", dc.dc_req_addr_out, e.addr);
        if (e.we) chk("req_wdata", dc.dc_req_wdata_out, e.wdata);
      end
      prev_val = dc.dc_req_val_out;
      if (stall) begin
        run++;
      end else if (run > 0) begin
        if (done_q.size() == 0) begin
          chk("extra_done", 32'd1, 32'd0);
        end else begin
          dn = done_q.pop_front();
          chk("stall_cycles", 32'(run), 32'(dn.stall));
          chk("rdata", rdata, dn.rdata);
        end
        run = 0;
      end
      if (mis || cyc == mis_exp_cyc)
        chk("misalign", 32'(mis), 32'(cyc == mis_exp_cyc));
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    txn_t t;
    req = 0; we = 0; size = 0; sign = 0; addr = 0; wdata = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_val", 32'(dc.dc_req_val_out), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mis", 32'(mis), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_be", 32'(dc.dc_req_be_out), 32'd0);
    chk("rst_addr", dc.dc_req_addr_out, 32'd0);
    chk("rst_wdata", dc.dc_req_wdata_out, 32'd0);
    chk("rst_we", 32'(dc.dc_req_we_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(mk(0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF, 1, 1));
    chk("ldw_rdata", rdata, 32'hDEADBEEF);
    issue(mk(0, 2'd0, 1, 32'h103, 0, 32'h80FFFFFF, 1, 1));
    chk("ldb_signed", rdata, 32'hFFFFFF80);
    issue(mk(0, 2'd0, 0, 32'h103, 0, 32'h80FFFFFF, 2, 3));
    chk("ldb_unsigned", rdata, 32'h00000080);
    issue(mk(1, 2'd1, 0, 32'h202, 32'h1234ABCD, 0, 5, 1));
    chk("st_keeps_rdata", rdata, 32'h00000080);
    issue(mk(0, 2'd2, 0, 32'h101, 0, 32'hCAFEF00D, 1, 2));
    issue(mk(0, 2'd1, 1, 32'h2, 0, 32'h8001_7FFF, 3, 1));
    issue(mk(0, 2'd3, 0, 32'h40, 0, 32'h0BAD_F00D, 1, 1));
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 150; i++) begin
      t = mk($urandom_range(0, 1), 2'($urandom_range(0, 3)),
             $urandom_range(0, 1), $urandom, $urandom, $urandom,
             $urandom_range(1, 4), $urandom_range(1, 4));
      issue(t);
      if ($urandom_range(0, 2) == 0) begin
        req = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);

    // Reset in WAIT, then a stray response.
    @(negedge clk);
    manual = 1'b1;
    dc.dc_req_ack_in = 1'b0;
    dc.dc_resp_val_in = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; size = 2'd2; sign = 1'b0; addr = 32'h300;
    @(posedge clk); #1;
    dc.dc_req_ack_in = 1'b1;
    @(posedge clk); #1;
    dc.dc_req_ack_in = 1'b0;
    chk("in_wait_stall", 32'(stall), 32'd1);
    rst_n = 1'b0;
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dc.dc_resp_val_in = 1'b1;
    dc.dc_resp_data_in = 32'h5555_5555;
    chk("rst_wait_stall", 32'(stall), 32'd0);
    chk("rst_wait_val", 32'(dc.dc_req_val_out), 32'd0);
    @(posedge clk); #1;
    dc.dc_resp_val_in = 1'b0;
    chk("stray_rdata", rdata, 32'd0);
    chk("stray_stall", 32'(stall), 32'd0);
    chk("stray_val", 32'(dc.dc_req_val_out), 32'd0);
    @(posedge clk); #1;
    chk("after_rdata", rdata, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
